// File: rtl/cpu_defs.sv
// Shared definitions for the fetch/decode instruction queue.
// Exports the queue entry layout ({instr, pc4}), the NOP used for masked
// outputs, and the fetch reset PC.
package cpu_defs;

    localparam int unsigned IQ_ENTRY_W = 64;
    localparam logic [31:0] NOP_INSTR  = 32'h0;
    localparam logic [31:0] RESET_PC   = 32'h0000_3000;

    // Queue entry: instr in [63:32], pc4 in [31:0]
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } iq_entry_t;

endpackage

// File: rtl/iq_storage.sv
// Entry storage for instr_queue: DEPTH x 64-bit register array.
// Ports: clk; we/waddr/wdata write port (rising edge);
//        raddr -> rdata asynchronous read port.
// No reset: entry validity is tracked by the owner's occupancy count.
module iq_storage
    import cpu_defs::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  iq_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output iq_entry_t     rdata
);

    iq_entry_t mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read port
    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode.
// Ports: clk, reset (sync, active-low);
//        InstrF/ADD4 fetch inputs, captured when enPC=1;
//        enPC fetch enable (combinational);
//        InstrD/PC4D/validD head entry to decode, readyD consume;
//        redirect taken jump/branch at the head (delay-slot semantics);
//        count occupancy.
module instr_queue
    import cpu_defs::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   InstrF,
    input  logic [31:0]   ADD4,
    output logic          enPC,
    output logic [31:0]   InstrD,
    output logic [31:0]   PC4D,
    output logic          validD,
    input  logic          readyD,
    input  logic          redirect,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] head, head_n;
    logic [AW-1:0] tail, tail_n;
    logic [CW-1:0] count_n;
    logic          full;
    logic          pop;
    logic          push;
    logic          redir_take;
    logic          we;
    iq_entry_t     wdata;
    iq_entry_t     rdata;

    iq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk   (clk),
        .we    (we),
        .waddr (tail),
        .wdata (wdata),
        .raddr (head),
        .rdata (rdata)
    );

    assign wdata      = '{instr: InstrF, pc4: ADD4};
    assign full       = (count == CW'(DEPTH));
    assign validD     = (count != '0);
    assign pop        = validD && readyD;
    assign redir_take = redirect && pop;
    assign push       = !full;
    // A taken redirect always frees fetch so the target is fetched next
    assign enPC       = redir_take || !full;

    // Head entry to decode, masked to zero when empty
    assign InstrD = validD ? rdata.instr : NOP_INSTR;
    assign PC4D   = validD ? rdata.pc4   : 32'h0;

    // Pointer/count next-state
    always_comb begin
        head_n  = head;
        tail_n  = tail;
        count_n = count;
        we      = 1'b0;
        if (redir_take) begin
            if (count >= CW'(2)) begin
                // Delay slot already queued at head+1: keep it, drop the rest and InstrF
                head_n  = head + AW'(1);
                tail_n  = head_n + AW'(1);
                count_n = CW'(1);
            end else begin
                // Delay slot is the instruction arriving this cycle
                we      = 1'b1;
                head_n  = tail;
                tail_n  = tail + AW'(1);
                count_n = CW'(1);
            end
        end else begin
            we = push;
            if (push) begin
                tail_n = tail + AW'(1);
            end
            if (pop) begin
                head_n = head + AW'(1);
            end
            count_n = count + CW'(push) - CW'(pop);
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_n;
            tail  <= tail_n;
            count <= count_n;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue (DEPTH=4).
// Each vector drives reset/readyD/redirect/InstrF/ADD4 for one cycle and
// checks count/validD/InstrD/PC4D/enPC in that same cycle before the edge.
module tb_instr_queue;

    logic        clk;
    logic        reset;
    logic [31:0] InstrF;
    logic [31:0] ADD4;
    logic        enPC;
    logic [31:0] InstrD;
    logic [31:0] PC4D;
    logic        validD;
    logic        readyD;
    logic        redirect;
    logic [2:0]  count;

    int unsigned n_checks;
    int unsigned n_fail;

    typedef struct {
        logic        chk;
        logic        rst_n;
        logic        rdy;
        logic        redir;
        logic [31:0] add4;
        int unsigned cnt;
        logic [31:0] pc4;
        logic        en;
    } vec_t;

    vec_t vecs[$];

    instr_queue #(.DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .InstrF   (InstrF),
        .ADD4     (ADD4),
        .enPC     (enPC),
        .InstrD   (InstrD),
        .PC4D     (PC4D),
        .validD   (validD),
        .readyD   (readyD),
        .redirect (redirect),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word tagged with its PC+4 so order is visible on InstrD too
    function automatic logic [31:0] mk(input logic [31:0] pc4);
        return 32'hFFFF_0000 | (pc4 & 32'h0000_FFFF);
    endfunction

    function automatic vec_t v(input logic chk, input logic rst_n, input logic rdy,
                               input logic redir, input logic [31:0] add4,
                               input int unsigned cnt, input logic [31:0] pc4,
                               input logic en);
        vec_t r;
        r.chk = chk; r.rst_n = rst_n; r.rdy = rdy; r.redir = redir;
        r.add4 = add4; r.cnt = cnt; r.pc4 = pc4; r.en = en;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check combinational outputs, leave the edge to come
    task automatic run(input vec_t x, input string tag);
        logic [31:0] exp_instr;
        @(negedge clk);
        reset    = x.rst_n;
        readyD   = x.rdy;
        redirect = x.redir;
        ADD4     = x.add4;
        InstrF   = mk(x.add4);
        #1;
        if (x.chk) begin
            exp_instr = (x.cnt != 0) ? mk(x.pc4) : 32'h0;
            check({tag, ".count"},  32'(count),  32'(x.cnt));
            check({tag, ".validD"}, 32'(validD), 32'(x.cnt != 0));
            check({tag, ".InstrD"}, InstrD,      exp_instr);
            check({tag, ".PC4D"},   PC4D,        (x.cnt != 0) ? x.pc4 : 32'h0);
            check({tag, ".enPC"},   32'(enPC),   32'(x.en));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        readyD   = 1'b0;
        redirect = 1'b0;
        InstrF   = 32'h0;
        ADD4     = 32'h0;

        //          chk rst rdy red add4          cnt pc4           en
        // reset, idle, fill to full
        vecs.push_back(v(0, 0, 0, 0, 32'h3004, 0, 32'h0,    1));
        vecs.push_back(v(1, 1, 0, 0, 32'h3004, 0, 32'h0,    1));
        vecs.push_back(v(1, 1, 0, 0, 32'h3008, 1, 32'h3004, 1));
        vecs.push_back(v(1, 1, 0, 0, 32'h300C, 2, 32'h3004, 1));
        vecs.push_back(v(1, 1, 0, 0, 32'h3010, 3, 32'h3004, 1));
        vecs.push_back(v(1, 1, 0, 0, 32'h3014, 4, 32'h3004, 0));
        vecs.push_back(v(1, 1, 0, 0, 32'h3014, 4, 32'h3004, 0));
        // drain: full+pop does not push, enPC returns the cycle after
        vecs.push_back(v(1, 1, 1, 0, 32'h3014, 4, 32'h3004, 0));
        vecs.push_back(v(1, 1, 1, 0, 32'h3014, 3, 32'h3008, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h3018, 3, 32'h300C, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h301C, 3, 32'h3010, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h3020, 3, 32'h3014, 1));
        // mid-stream reset with count=3
        vecs.push_back(v(1, 0, 0, 0, 32'h3024, 3, 32'h3018, 1));
        vecs.push_back(v(1, 1, 0, 0, 32'h3004, 0, 32'h0,    1));
        // steady stream
        vecs.push_back(v(1, 1, 1, 0, 32'h3008, 1, 32'h3004, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h300C, 1, 32'h3008, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h3010, 1, 32'h300C, 1));
        // redirect with count==1: incoming 0x3014 is the delay slot, target 0x4004
        vecs.push_back(v(1, 1, 1, 1, 32'h3014, 1, 32'h3010, 1));
        vecs.push_back(v(1, 1, 0, 0, 32'h4004, 1, 32'h3014, 1));
        vecs.push_back(v(1, 1, 0, 0, 32'h4008, 2, 32'h3014, 1));
        vecs.push_back(v(1, 1, 0, 0, 32'h400C, 3, 32'h3014, 1));
        // redirect without readyD while full: no change
        vecs.push_back(v(1, 1, 0, 1, 32'h4010, 4, 32'h3014, 0));
        vecs.push_back(v(1, 1, 0, 0, 32'h4010, 4, 32'h3014, 0));
        // redirect with count==4: keep 0x4004, drop 0x4008/0x400C/InstrF, target 0x5004
        vecs.push_back(v(1, 1, 1, 1, 32'h4010, 4, 32'h3014, 1));
        vecs.push_back(v(1, 1, 0, 0, 32'h5004, 1, 32'h4004, 1));
        vecs.push_back(v(1, 1, 0, 0, 32'h5008, 2, 32'h4004, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h500C, 3, 32'h4004, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h5010, 3, 32'h5004, 1));

        foreach (vecs[i]) begin
            run(vecs[i], $sformatf("vec%0d", i));
        end

        // Hand sequence: redirect at head with count==3 (0x3004/0x3008/0x300C)
        run(v(0, 0, 0, 0, 32'h3004, 0, 32'h0,    1), "r3.rst");
        run(v(1, 1, 0, 0, 32'h3004, 0, 32'h0,    1), "r3.f0");
        run(v(1, 1, 0, 0, 32'h3008, 1, 32'h3004, 1), "r3.f1");
        run(v(1, 1, 0, 0, 32'h300C, 2, 32'h3004, 1), "r3.f2");
        run(v(1, 1, 1, 1, 32'h3010, 3, 32'h3004, 1), "r3.redir");
        run(v(1, 1, 0, 0, 32'h6004, 1, 32'h3008, 1), "r3.slot");
        run(v(1, 1, 1, 0, 32'h6008, 2, 32'h3008, 1), "r3.pop");
        run(v(1, 1, 1, 0, 32'h600C, 2, 32'h6004, 1), "r3.target");

        // Hand sequence: reset while redirect/readyD active discards everything
        run(v(1, 0, 1, 1, 32'h6010, 2, 32'h6008, 1), "rr.assert");
        run(v(1, 1, 0, 0, 32'h3004, 0, 32'h0,    1), "rr.after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
